fp32_divide_seq: RTL and testbench

Sequential IEEE-754 single-precision divider for the neural-network datapath: result = operand_1 / operand_2. It is the inverse of the combinational FP32 multiply and uses the same operand conventions: flush-to-zero, no NaN/Inf inputs, and saturating overflow. It computes a 26-bit quotient by restoring division, one bit per cycle, behind valid/ready handshakes on both sides.

---
 rtl/fp32_divide_seq.sv | 208 ++++++++++++++++++++
 tb/tb_fp32_divide_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_divide_seq.sv
// Sequential FP32 divider: result = operand_1 / operand_2.
// Restoring division produces a 26-bit quotient one bit per cycle. The quotient is then
// normalised and rounded. Denormals flush to zero, NaN/Inf inputs are not supported,
// and overflow saturates. Both sides use valid/ready handshakes.
module fp32_divide_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_sign;
    logic [7:0]  r_e1;
    logic [7:0]  r_e2;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [25:0] r_q;
    logic [4:0]  r_count;
    logic [31:0] r_result;
    logic        r_dbz;

    logic        w_accept;
    logic        w_inSign;
    logic        w_special;
    logic [31:0] w_specResult;
    logic        w_specDbz;

    logic        w_geq;
    logic [24:0] w_remSub;
    logic [24:0] w_remNext;

    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_adj;
    logic        w_roundUp;
    logic [23:0] w_mantSum;
    logic        w_carry;
    logic [22:0] w_mantFinal;
    logic [9:0]  w_exp;
    logic        w_overflow;
    logic        w_underflow;
    logic [31:0] w_normResult;

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign div_by_zero = r_dbz;

    assign w_accept = in_valid && in_ready;
    assign w_inSign = operand_1[31] ^ operand_2[31];

    // Special-operand detection, checked in priority order, so that these cases skip the divider.
    always_comb begin
        w_special    = 1'b0;
        w_specResult = 32'd0;
        w_specDbz    = 1'b0;
        if ((operand_1[30:23] == 8'hFF) || (operand_2[30:23] == 8'hFF)) begin
            w_special    = 1'b1;
            w_specResult = 32'd0;
        end else if (operand_2[30:23] == 8'd0) begin
            w_special    = 1'b1;
            w_specResult = {w_inSign, 8'hFF, 23'd0};
            w_specDbz    = 1'b1;
        end else if (operand_1[30:23] == 8'd0) begin
            w_special    = 1'b1;
            w_specResult = {w_inSign, 31'd0};
        end
    end

    // One restoring-division step. R stays below 2*mb, so the left shift never loses a set bit.
    assign w_geq     = (r_rem >= {1'b0, r_mb});
    assign w_remSub  = w_geq ? (r_rem - {1'b0, r_mb}) : r_rem;
    assign w_remNext = w_remSub << 1;

    // Normalise the quotient, round (guard AND sticky), then build the exponent and saturate.
    always_comb begin
        if (r_q[25]) begin
            w_mant   = r_q[24:2];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (r_rem != 25'd0);
            w_adj    = 1'b0;
        end else begin
            w_mant   = r_q[23:1];
            w_guard  = r_q[0];
            w_sticky = (r_rem != 25'd0);
            w_adj    = 1'b1;
        end
    end

    assign w_roundUp   = w_guard & w_sticky;
    assign w_mantSum   = {1'b0, w_mant} + {23'd0, w_roundUp};
    assign w_carry     = w_mantSum[23];
    assign w_mantFinal = w_carry ? 23'd0 : w_mantSum[22:0];
    assign w_exp       = {2'b00, r_e1} - {2'b00, r_e2} + 10'd127
                         - {9'd0, w_adj} + {9'd0, w_carry};
    assign w_overflow  = !w_exp[9] && (w_exp >= 10'd255);
    assign w_underflow = w_exp[9] || (w_exp == 10'd0);

    // Select between the saturated, flushed and normal result.
    always_comb begin
        if (w_overflow) begin
            w_normResult = {r_sign, 8'hFF, 23'd0};
        end else if (w_underflow) begin
            w_normResult = {r_sign, 31'd0};
        end else begin
            w_normResult = {r_sign, w_exp[7:0], w_mantFinal};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Special operands go straight to DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_special ? DONE : DIV;
                end
            end
            DIV: begin
                if (r_count == 5'd25) begin
                    w_nextState = NORM;
                end
            end
            NORM: begin
                w_nextState = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture operands, iterate the divider, and register the final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_e1     <= 8'd0;
            r_e2     <= 8'd0;
            r_mb     <= 24'd0;
            r_rem    <= 25'd0;
            r_q      <= 26'd0;
            r_count  <= 5'd0;
            r_result <= 32'd0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign  <= w_inSign;
                        r_e1    <= operand_1[30:23];
                        r_e2    <= operand_2[30:23];
                        r_mb    <= {1'b1, operand_2[22:0]};
                        r_rem   <= {2'b01, operand_1[22:0]};
                        r_q     <= 26'd0;
                        r_count <= 5'd0;
                        if (w_special) begin
                            r_result <= w_specResult;
                            r_dbz    <= w_specDbz;
                        end
                    end
                end
                DIV: begin
                    r_q     <= {r_q[24:0], w_geq};
                    r_rem   <= w_remNext;
                    r_count <= r_count + 5'd1;
                end
                NORM: begin
                    r_result <= w_normResult;
                    r_dbz    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divide_seq.sv
// Testbench for fp32_divide_seq. An arithmetic reference model computes every accepted
// operation into a scoreboard queue. Each cycle that a result is visible, that result is
// compared against the queue.
module tb_fp32_divide_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;

    int          checks;
    int          errors;
    int          cycle;
    logic [32:0] expQ[$];

    fp32_divide_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count edges so that latencies can be measured in cycles.
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference divider, returns {div_by_zero, result}. The quotient is floor(ma*2^25/mb).
    function automatic logic [32:0] modelDivide(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, mant, guardBit, sticky, adj, e;
        longint ma, mb, num, q;
        logic   remNonZero;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b0, 32'd0};
        if (eb == 0) return {1'b1, s, 8'hFF, 23'd0};
        if (ea == 0) return {1'b0, s, 31'd0};
        ma  = longint'(8388608) + longint'(a[22:0]);
        mb  = longint'(8388608) + longint'(b[22:0]);
        num = ma * longint'(33554432);
        q   = num / mb;
        remNonZero = (num % mb) != 0;
        if (q >= longint'(33554432)) begin
            mant     = int'((q / 4) % 8388608);
            guardBit = int'((q / 2) % 2);
            sticky   = int'(q % 2) | int'(remNonZero);
            adj      = 0;
        end else begin
            mant     = int'((q / 2) % 8388608);
            guardBit = int'(q % 2);
            sticky   = int'(remNonZero);
            adj      = 1;
        end
        if (guardBit == 1 && sticky == 1) mant = mant + 1;
        if (mant == 8388608) begin
            mant = 0;
            adj  = adj - 1;
        end
        e = ea - eb + 127 - adj;
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Scoreboard compare. It runs on falling edges, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            checkOutput("resetOutValid", 32'(out_valid), 32'd0);
            checkOutput("resetResult", result, 32'd0);
            checkOutput("resetDbz", 32'(div_by_zero), 32'd0);
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("scoreResult", result, expQ[0][31:0]);
                    checkOutput("scoreDbz", 32'(div_by_zero), 32'(expQ[0][32]));
                    checkOutput("scoreInReadyLow", 32'(in_ready), 32'd0);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
            if (in_valid && in_ready) expQ.push_back(modelDivide(operand_1, operand_2));
        end
    end

    // Offer an operand pair until it is accepted. acceptCycle is the index of the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int acceptCycle);
        bit accepted;
        accepted    = 1'b0;
        acceptCycle = cycle;
        operand_1   = a;
        operand_2   = b;
        in_valid    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acceptCycle = cycle;
                accepted    = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    // Wait for out_valid. Check that in_ready stays low while the operation is busy.
    task automatic waitValid(output int validCycle);
        bit seen;
        seen       = 1'b0;
        validCycle = cycle;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                validCycle = cycle;
                seen       = 1'b1;
                break;
            end
            checkOutput("busyInReady", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        if (!seen) checkOutput("validTimeout", 32'd0, 32'd1);
    endtask

    // Hold backpressure for the given number of cycles, then complete the handshake.
    task automatic drainResult(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bpOutValid", 32'(out_valid), 32'd1);
            checkOutput("bpInReady", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("drainInReady", 32'(in_ready), 32'd1);
        checkOutput("drainOutValid", 32'(out_valid), 32'd0);
    endtask

    // Run one full operation. Check the latency and, if requested, a hand-computed result.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input int expLat, input int hold,
                         input bit checkLit, input logic [31:0] litRes, input logic litDbz);
        int k, v;
        applyStimulus(a, b, k);
        waitValid(v);
        checkOutput("latency", 32'(v - k), 32'(expLat));
        if (checkLit) begin
            checkOutput("litResult", result, litRes);
            checkOutput("litDbz", 32'(div_by_zero), 32'(litDbz));
        end
        drainResult(hold);
    endtask

    // Main sequence: reset, model pins, directed cases, random ops, then mid-operation reset.
    initial begin
        logic [32:0] m;
        logic [31:0] a, b;
        logic [7:0]  ea, eb;
        int          k, lat;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operand_1 = 32'd0;
        operand_2 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstResult", result, 32'd0);
        checkOutput("rstDbz", 32'(div_by_zero), 32'd0);

        m = modelDivide(32'h40C00000, 32'h40000000);
        checkOutput("model6div2", m[31:0], 32'h40400000);
        m = modelDivide(32'h3F800000, 32'h40400000);
        checkOutput("model1div3", m[31:0], 32'h3EAAAAAB);
        m = modelDivide(32'hBFC00000, 32'h3F000000);
        checkOutput("modelNeg", m[31:0], 32'hC0400000);
        m = modelDivide(32'h3F800000, 32'h00000000);
        checkOutput("modelDbz", {m[32], m[30:0]}, 32'hFF800000);
        m = modelDivide(32'h7F000000, 32'h3E800000);
        checkOutput("modelOvf", m[31:0], 32'h7F800000);
        m = modelDivide(32'h00800000, 32'h4B000000);
        checkOutput("modelUnf", m[31:0], 32'h00000000);

        runOp(32'h40C00000, 32'h40000000, 27, 10, 1'b1, 32'h40400000, 1'b0);
        runOp(32'h3F800000, 32'h40400000, 27, 0, 1'b1, 32'h3EAAAAAB, 1'b0);
        runOp(32'hBFC00000, 32'h3F000000, 27, 1, 1'b1, 32'hC0400000, 1'b0);
        runOp(32'h3F800000, 32'h00000000, 0, 0, 1'b1, 32'h7F800000, 1'b1);
        runOp(32'h80000000, 32'h40000000, 0, 2, 1'b1, 32'h80000000, 1'b0);
        runOp(32'h7F800000, 32'h3F800000, 0, 0, 1'b1, 32'h00000000, 1'b0);
        runOp(32'h7F000000, 32'h3E800000, 27, 0, 1'b1, 32'h7F800000, 1'b0);
        runOp(32'h00800000, 32'h4B000000, 27, 0, 1'b1, 32'h00000000, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ea = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3) * 85) : 8'($urandom_range(60, 190));
            eb = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3) * 85) : 8'($urandom_range(60, 190));
            if ($urandom_range(0, 9) == 0) eb = 8'hFF;
            if ($urandom_range(0, 9) == 0) ea = 8'd0;
            a   = {1'($urandom), ea, 23'($urandom)};
            b   = {1'($urandom), eb, 23'($urandom)};
            lat = (ea == 8'hFF || eb == 8'hFF || ea == 8'd0 || eb == 8'd0) ? 0 : 27;
            runOp(a, b, lat, int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
        end

        applyStimulus(32'h40C00000, 32'h40000000, k);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstResult", result, 32'd0);
        checkOutput("midRstDbz", 32'(div_by_zero), 32'd0);
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstInReady", 32'(in_ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            checkOutput("postRstNoOutput", 32'(out_valid), 32'd0);
        end
        runOp(32'h40C00000, 32'h40000000, 27, 0, 1'b1, 32'h40400000, 1'b0);

        repeat (2) @(posedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
